// File: rtl/cnn_buf_pkg.sv
// Shared definitions for the feature-map BUFFER, its writer and its reader.
// Provides address-width helpers, the reader FSM state type and the column offset.
// No ports; import with `import cnn_buf_pkg::*;`.
package cnn_buf_pkg;

  // Address width for a dimension of the given depth; must match BUFFER exactly.
  function automatic int addr_bits(input int depth);
    return $clog2(depth);
  endfunction

  // The BUFFER stores each row shifted right by KERNEL_SIZE-1 columns
  // (room for the convolution halo), so readers add this to the column index.
  function automatic int col_offset(input int kernel_size);
    return kernel_size - 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/buffer_read_ctrl_if.sv
// Bundle of the BUFFER read port and the downstream valid/ready stream.
// master: the read controller (drives re/addr and the stream, samples d_out/ready).
// slave:  the BUFFER plus downstream consumer (drives d_out and ready).
interface buffer_read_ctrl_if
  import cnn_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_H    = 6,
  parameter int DEPTH_W    = 6,
  parameter int CO         = 8
) ();

  localparam int ADDR_W = addr_bits(DEPTH_W);
  localparam int ADDR_H = addr_bits(DEPTH_H);
  localparam int ADDR_C = addr_bits(CO);

  // BUFFER read port
  logic                  buf_re;
  logic [ADDR_W+1:0]     buf_addr_x;
  logic [ADDR_H+1:0]     buf_addr_y;
  logic [ADDR_C+1:0]     buf_addr_c;
  logic [DATA_WIDTH-1:0] buf_d_out;

  // Output stream
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_eol;

  modport master (
    output buf_re, buf_addr_x, buf_addr_y, buf_addr_c,
    output m_valid, m_data, m_last, m_eol,
    input  buf_d_out, m_ready
  );

  modport slave (
    input  buf_re, buf_addr_x, buf_addr_y, buf_addr_c,
    input  m_valid, m_data, m_last, m_eol,
    output buf_d_out, m_ready
  );

endinterface

// File: rtl/buf_skid_fifo.sv
// 2-entry FIFO holding {data, last, eol} words captured from the BUFFER read port.
// Latency: a pushed word is visible at pop_* the cycle after the push edge.
// Backpressure: push_rdy drops when full; pop head holds stable until popped.
// Ports: clk/rst, push_vld/push_rdy/push_dat, pop_vld/pop_rdy/pop_dat, occ (0..2).
module buf_skid_fifo #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic [1:0]   occ
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign push_rdy = (cnt_q != 2'd2);
  assign pop_vld  = (cnt_q != 2'd0);
  assign pop_dat  = mem_q[rd_q];
  assign occ      = cnt_q;

  assign push = push_vld && push_rdy;
  assign pop  = pop_vld && pop_rdy;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    // Simultaneous push and pop leaves the count unchanged.
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/buffer_read_ctrl.sv
// Read-side sequencer: walks the CO x DEPTH_H x DEPTH_W map (channel, row, column)
// and streams it out. First word is valid 2 cycles after start, then 1 word/cycle.
// Backpressure: reads are throttled so the 2-entry skid FIFO never overflows.
// Ports: clk, rst (async, active high), start, busy, done, bus (BUFFER read + stream).
module buffer_read_ctrl
  import cnn_buf_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 4,
  parameter int DEPTH_H     = 6,
  parameter int DEPTH_W     = 6,
  parameter int CO          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  buffer_read_ctrl_if.master  bus
);

  localparam int ADDR_W  = addr_bits(DEPTH_W);
  localparam int ADDR_H  = addr_bits(DEPTH_H);
  localparam int ADDR_C  = addr_bits(CO);
  localparam int XW      = ADDR_W + 2;
  localparam int COL_OFF = col_offset(KERNEL_SIZE);

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(DEPTH_W - 1);
  localparam logic [ADDR_H-1:0] ROW_LAST = ADDR_H'(DEPTH_H - 1);
  localparam logic [ADDR_C-1:0] CH_LAST  = ADDR_C'(CO - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  eol;
  } word_t;

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_H-1:0] row_q, row_d;
  logic [ADDR_C-1:0] ch_q, ch_d;
  logic              inflight_q, inflight_d;
  logic              tag_last_q, tag_last_d;
  logic              tag_eol_q, tag_eol_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  word_t             fifo_push_dat;
  word_t             fifo_pop_dat;
  logic              fifo_push_rdy;
  logic              fifo_pop_vld;
  logic              fifo_pop;
  logic [1:0]        fifo_occ;

  logic [2:0]        pending;
  logic              rd_issue;
  logic              drained;
  logic              at_col_end, at_row_end, at_ch_end;
  logic              in_run;

  // The word read last cycle arrives on d_out now, with the tags computed at issue.
  assign fifo_push_dat = '{data: bus.buf_d_out, last: tag_last_q, eol: tag_eol_q};

  buf_skid_fifo #(
    .W ($bits(word_t))
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push_vld (inflight_q),
    .push_rdy (fifo_push_rdy),
    .push_dat (fifo_push_dat),
    .pop_vld  (fifo_pop_vld),
    .pop_rdy  (bus.m_ready),
    .pop_dat  (fifo_pop_dat),
    .occ      (fifo_occ)
  );

  assign fifo_pop = fifo_pop_vld && bus.m_ready;

  // Words that will still occupy or be headed for the FIFO after this edge.
  // Counting the pop happening on the same edge is what allows 1 word/cycle
  // with only two entries; a new read is allowed only while this is below 2.
  assign pending  = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, fifo_pop};
  assign in_run   = (state_q == ST_RUN);
  assign rd_issue = in_run && (pending < 3'd2);

  // Nothing left after this edge: FIFO empties and no read outstanding.
  assign drained  = (({1'b0, fifo_occ} - {2'b00, fifo_pop}) == 3'd0) && !inflight_q;

  assign at_col_end = (col_q == COL_LAST);
  assign at_row_end = (row_q == ROW_LAST);
  assign at_ch_end  = (ch_q  == CH_LAST);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    ch_d       = ch_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    inflight_d = rd_issue;
    tag_last_d = at_ch_end && at_row_end && at_col_end;
    tag_eol_d  = at_col_end;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
          ch_d    = '0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (rd_issue) begin
          if (at_col_end) begin
            col_d = '0;
            if (at_row_end) begin
              row_d = '0;
              if (at_ch_end) begin
                ch_d    = '0;
                state_d = ST_DRAIN;
              end else begin
                ch_d = ch_q + 1'b1;
              end
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      ch_q       <= '0;
      inflight_q <= 1'b0;
      tag_last_q <= 1'b0;
      tag_eol_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      ch_q       <= ch_d;
      inflight_q <= inflight_d;
      tag_last_q <= tag_last_d;
      tag_eol_q  <= tag_eol_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // The issue throttle guarantees room for every captured word.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      assert (!inflight_q || fifo_push_rdy);
    end
  end

  // Addresses are forced to zero outside RUN so the port is quiet when idle.
  assign bus.buf_re     = rd_issue;
  assign bus.buf_addr_x = in_run ? (XW'(col_q) + XW'(COL_OFF)) : '0;
  assign bus.buf_addr_y = in_run ? {2'b00, row_q} : '0;
  assign bus.buf_addr_c = in_run ? {2'b00, ch_q}  : '0;

  assign bus.m_valid = fifo_pop_vld;
  assign bus.m_data  = fifo_pop_dat.data;
  assign bus.m_last  = fifo_pop_dat.last;
  assign bus.m_eol   = fifo_pop_dat.eol;

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_buffer_read_ctrl.sv
// Bench for buffer_read_ctrl: models the BUFFER, drives random backpressure and
// checks every streamed word, read address and done pulse against a raster-order model.
module tb_buffer_read_ctrl;

  localparam int DATA_WIDTH  = 16;
  localparam int KERNEL_SIZE = 4;
  localparam int DEPTH_H     = 6;
  localparam int DEPTH_W     = 6;
  localparam int CO          = 8;
  localparam int TOTAL       = CO * DEPTH_H * DEPTH_W;
  localparam int RUN_BUDGET  = 6000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  buffer_read_ctrl_if #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_H    (DEPTH_H),
    .DEPTH_W    (DEPTH_W),
    .CO         (CO)
  ) bif ();

  buffer_read_ctrl #(
    .DATA_WIDTH  (DATA_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE),
    .DEPTH_H     (DEPTH_H),
    .DEPTH_W     (DEPTH_W),
    .CO          (CO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int errs = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: word k of the map in channel/row/column raster order.
  function automatic int ref_c(input int k); return k / (DEPTH_H * DEPTH_W); endfunction
  function automatic int ref_y(input int k); return (k / DEPTH_W) % DEPTH_H; endfunction
  function automatic int ref_x(input int k); return k % DEPTH_W; endfunction
  function automatic int ref_val(input int k);
    return ref_c(k) * 64 + ref_y(k) * 8 + ref_x(k);
  endfunction

  // BUFFER model: contents c*64 + y*8 + x stored at column x + KERNEL_SIZE-1,
  // registered read with one cycle of latency.
  function automatic logic [DATA_WIDTH-1:0] buf_word(input int ax, input int ay, input int ac);
    int x;
    x = ax - (KERNEL_SIZE - 1);
    if (x < 0 || x >= DEPTH_W || ay >= DEPTH_H || ac >= CO) return 16'hDEAD;
    return DATA_WIDTH'(ac * 64 + ay * 8 + x);
  endfunction

  always @(posedge clk) begin
    if (bif.buf_re)
      bif.buf_d_out <= buf_word(int'(bif.buf_addr_x), int'(bif.buf_addr_y), int'(bif.buf_addr_c));
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Scoreboard state
  bit mon_en = 1'b0;
  int exp_idx;        // next word expected on the stream
  int rd_idx;         // next read expected on the BUFFER port
  int outst;          // reads issued but not yet accepted downstream
  int done_cnt;
  int last_xfer_edge;
  bit prev_done;

  task automatic reset_model();
    exp_idx        = 0;
    rd_idx         = 0;
    outst          = 0;
    done_cnt       = 0;
    last_xfer_edge = -1;
    prev_done      = 1'b0;
  endtask

  always @(negedge clk) begin
    bit xfer;
    if (mon_en && !rst) begin
      xfer = bif.m_valid && bif.m_ready;
      if (bif.buf_re) begin
        chk("re_while_busy", int'(busy), 1);
        chk("re_room", int'((outst - int'(xfer)) < 2), 1);
        if (rd_idx < TOTAL) begin
          chk("addr_x", int'(bif.buf_addr_x), ref_x(rd_idx) + KERNEL_SIZE - 1);
          chk("addr_y", int'(bif.buf_addr_y), ref_y(rd_idx));
          chk("addr_c", int'(bif.buf_addr_c), ref_c(rd_idx));
        end else begin
          chk("read_count", rd_idx, TOTAL - 1);
        end
        rd_idx++;
      end
      if (bif.m_valid) begin
        if (exp_idx < TOTAL) begin
          chk("m_data", int'(bif.m_data), ref_val(exp_idx));
          chk("m_eol",  int'(bif.m_eol),  int'(ref_x(exp_idx) == DEPTH_W - 1));
          chk("m_last", int'(bif.m_last), int'(exp_idx == TOTAL - 1));
        end else begin
          chk("word_count", exp_idx, TOTAL - 1);
        end
        if (bif.m_ready) begin
          exp_idx++;
          last_xfer_edge = cyc + 1;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_words", exp_idx, TOTAL);
        chk("done_timing", cyc, last_xfer_edge);
        chk("done_width", int'(prev_done), 0);
      end
      prev_done = done;
      outst = outst + int'(bif.buf_re) - int'(xfer);
    end
  end

  // Called at #1 after a posedge: pulses start for one cycle.
  task automatic begin_map();
    reset_model();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Drives m_ready at pct% until done, optionally re-pulsing start mid-map.
  // Returns at #1 in the cycle after the done pulse.
  task automatic run_to_done(input string nm, input int pct, input int restart_at,
                             input int exp_words, input int exp_dones);
    int n = 0;
    bit restarted = 1'b0;
    while (done_cnt == 0 && n < RUN_BUDGET) begin
      @(posedge clk);
      #1;
      n++;
      bif.m_ready = (pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < pct);
      if (restart_at >= 0 && !restarted && exp_idx >= restart_at) begin
        start     = 1'b1;
        restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, "_finished"}, int'(done_cnt != 0), 1);
    chk({nm, "_words"}, exp_idx, exp_words);
    chk({nm, "_reads"}, rd_idx, exp_words);
    chk({nm, "_dones"}, done_cnt, exp_dones);
    chk({nm, "_busy_after"}, int'(busy), 0);
  endtask

  typedef struct {
    string name;
    int    pct;
    int    restart_at;
    int    exp_words;
    int    exp_dones;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    vecs[0] = '{name: "ready100",   pct: 100, restart_at: -1,  exp_words: TOTAL, exp_dones: 1};
    vecs[1] = '{name: "ready50",    pct: 50,  restart_at: -1,  exp_words: TOTAL, exp_dones: 1};
    vecs[2] = '{name: "ready80",    pct: 80,  restart_at: -1,  exp_words: TOTAL, exp_dones: 1};
    vecs[3] = '{name: "restart100", pct: 70,  restart_at: 100, exp_words: TOTAL, exp_dones: 1};
    vecs[4] = '{name: "ready20",    pct: 20,  restart_at: -1,  exp_words: TOTAL, exp_dones: 1};

    bif.m_ready = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    reset_model();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   int'(busy), 0);
    chk("rst_done",   int'(done), 0);
    chk("rst_re",     int'(bif.buf_re), 0);
    chk("rst_valid",  int'(bif.m_valid), 0);
    chk("rst_last",   int'(bif.m_last), 0);
    chk("rst_eol",    int'(bif.m_eol), 0);
    chk("rst_addr_x", int'(bif.buf_addr_x), 0);
    chk("rst_addr_y", int'(bif.buf_addr_y), 0);
    chk("rst_addr_c", int'(bif.buf_addr_c), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // First-word latency and first read address, then full map at ready=1
    bif.m_ready = 1'b1;
    begin_map();
    chk("lat_busy",   int'(busy), 1);
    chk("lat_re",     int'(bif.buf_re), 1);
    chk("lat_addr_x", int'(bif.buf_addr_x), KERNEL_SIZE - 1);
    chk("lat_addr_y", int'(bif.buf_addr_y), 0);
    chk("lat_addr_c", int'(bif.buf_addr_c), 0);
    chk("lat_valid0", int'(bif.m_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_valid1", int'(bif.m_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_valid2", int'(bif.m_valid), 1);
    chk("lat_data2",  int'(bif.m_data), 0);
    run_to_done("first", 100, -1, TOTAL, 1);

    // Downstream stalled from the start: two reads, then the port stays quiet
    @(posedge clk);
    #1;
    bif.m_ready = 1'b0;
    begin_map();
    repeat (20) @(posedge clk);
    #1;
    chk("hold_reads", rd_idx, 2);
    chk("hold_re",    int'(bif.buf_re), 0);
    chk("hold_valid", int'(bif.m_valid), 1);
    chk("hold_data",  int'(bif.m_data), 0);
    run_to_done("hold", 100, -1, TOTAL, 1);

    // Table of randomized-backpressure runs
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      begin_map();
      run_to_done(vecs[i].name, vecs[i].pct, vecs[i].restart_at,
                  vecs[i].exp_words, vecs[i].exp_dones);
    end

    // Back-to-back: start in the cycle right after the previous done pulse
    begin_map();
    run_to_done("b2b", 60, -1, TOTAL, 1);

    // Reset in the middle of a map
    @(posedge clk);
    #1;
    begin_map();
    n = 0;
    while (exp_idx < 150 && n < RUN_BUDGET) begin
      @(posedge clk);
      #1;
      n++;
      bif.m_ready = (int'($urandom_range(0, 99)) < 60);
    end
    chk("mid_reached", int'(exp_idx >= 150), 1);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_busy",  int'(busy), 0);
    chk("arst_done",  int'(done), 0);
    chk("arst_re",    int'(bif.buf_re), 0);
    chk("arst_valid", int'(bif.m_valid), 0);
    chk("arst_last",  int'(bif.m_last), 0);
    chk("arst_eol",   int'(bif.m_eol), 0);
    chk("arst_addr_x", int'(bif.buf_addr_x), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bif.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_valid", int'(bif.m_valid), 0);
      chk("post_rst_busy",  int'(busy), 0);
      chk("post_rst_re",    int'(bif.buf_re), 0);
    end
    reset_model();
    mon_en = 1'b1;
    begin_map();
    run_to_done("after_rst", 100, -1, TOTAL, 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
